// File: rtl/ibr128_seq_pkg.sv
// Shared state encoding and register-field positions for the IBR128 bus sequencer.
package ibr128_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_DIN,
      WR_GO,
      RD_STAT,
      CHK_STAT,
      RD_DOUT,
      WR_STOP,
      RESP
   } state_t;

   localparam int unsigned ENABLE_BIT     = 0;
   localparam int unsigned ENCRYPT_BIT    = 1;
   localparam int unsigned STAT_READY_BIT = 0;
   localparam int unsigned BEATS          = 4;

   function automatic logic [31:0] ctrl_word(input logic encrypt, input logic enable);
      logic [31:0] w;
      w = '0;
      w[ENABLE_BIT]  = enable;
      w[ENCRYPT_BIT] = encrypt;
      return w;
   endfunction

endpackage

// File: rtl/ibr128_seq_if.sv
// Job/result stream handshakes plus the IBR128 register port driven by ibr128_seq.
interface ibr128_seq_if;

   logic         job_valid;
   logic         job_ready;
   logic         job_encrypt;
   logic [127:0] job_data;
   logic         res_valid;
   logic         res_ready;
   logic [127:0] res_data;
   logic         res_err;
   logic         CS;
   logic         Write;
   logic         Read;
   logic [4:0]   Addr;
   logic [31:0]  WData;
   logic [31:0]  RData;

   modport master (
      input  job_valid, job_encrypt, job_data, res_ready, RData,
      output job_ready, res_valid, res_data, res_err, CS, Write, Read, Addr, WData
   );

   modport slave (
      output job_valid, job_encrypt, job_data, res_ready, RData,
      input  job_ready, res_valid, res_data, res_err, CS, Write, Read, Addr, WData
   );

endinterface

// File: rtl/ibr128_seq.sv
// Sequencer: writes one 128-bit block to IBR128, starts it, polls ready, reads the result back.
// Optional poll timeout enabled by defining IBR128_SEQ_TIMEOUT_EN.
module ibr128_seq
   import ibr128_seq_pkg::*;
#(
   parameter logic [4:0] ADDR_CTRL = 5'd0,
   parameter logic [4:0] ADDR_STAT = 5'd1,
   parameter logic [4:0] ADDR_DIN  = 5'd4,
   parameter logic [4:0] ADDR_DOUT = 5'd12
`ifdef IBR128_SEQ_TIMEOUT_EN
   ,parameter logic [15:0] POLL_MAX = 16'd1023
`endif
) (
   input  logic Clk,
   input  logic Rst,
   ibr128_seq_if.master bus
);

   state_t       state, state_nx;
   logic [2:0]   beat;
   logic [1:0]   cap_idx;
   logic [127:0] din_q;
   logic [127:0] res_q;
   logic         enc_q;
   logic         idle_ready;
   logic         stat_ready;
   logic         timeout;
   logic         cs, wr, rd;
   logic [4:0]   addr;
   logic [31:0]  wdata;

   assign idle_ready = (state == IDLE) && !Rst;
   assign stat_ready = bus.RData[STAT_READY_BIT];
   // Read data lags the strobe by one cycle, so beat k stores word k-1.
   assign cap_idx    = beat[1:0] - 2'd1;

`ifdef IBR128_SEQ_TIMEOUT_EN
   logic [15:0] poll_cnt;
   logic [15:0] poll_inc;
   logic        err_q;

   assign poll_inc = poll_cnt + 16'd1;
   assign timeout  = (state == CHK_STAT) && !stat_ready && (poll_inc == POLL_MAX);

   always_ff @(posedge Clk) begin
      if (Rst) begin
         poll_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         if (state == WR_GO)
            poll_cnt <= '0;
         else if (state == CHK_STAT && !stat_ready)
            poll_cnt <= poll_inc;
         if (timeout)
            err_q <= 1'b1;
         else if (state == RESP && bus.res_ready)
            err_q <= 1'b0;
      end
   end

   assign bus.res_err = err_q;
`else
   assign timeout     = 1'b0;
   assign bus.res_err = 1'b0;
`endif

   always_ff @(posedge Clk) begin
      if (Rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         beat  <= '0;
         din_q <= '0;
         enc_q <= 1'b0;
         res_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.job_valid) begin
                  din_q <= bus.job_data;
                  enc_q <= bus.job_encrypt;
                  res_q <= '0;
                  beat  <= '0;
               end
            end
            WR_DIN, RD_DOUT: beat <= (state_nx == state) ? beat + 3'd1 : '0;
            default: ;
         endcase
         if (state == RD_DOUT && beat != '0)
            res_q[{cap_idx, 5'd0} +: 32] <= bus.RData;
      end
   end

   always_comb begin
      state_nx = state;
      cs       = 1'b0;
      wr       = 1'b0;
      rd       = 1'b0;
      addr     = '0;
      wdata    = '0;
      case (state)
         IDLE: begin
            if (bus.job_valid)
               state_nx = WR_DIN;
         end
         WR_DIN: begin
            cs    = 1'b1;
            wr    = 1'b1;
            addr  = ADDR_DIN + {3'b0, beat[1:0]};
            wdata = din_q[{beat[1:0], 5'd0} +: 32];
            if (beat == 3'(BEATS - 1))
               state_nx = WR_GO;
         end
         WR_GO: begin
            cs       = 1'b1;
            wr       = 1'b1;
            addr     = ADDR_CTRL;
            wdata    = ctrl_word(enc_q, 1'b1);
            state_nx = RD_STAT;
         end
         RD_STAT: begin
            cs       = 1'b1;
            rd       = 1'b1;
            addr     = ADDR_STAT;
            state_nx = CHK_STAT;
         end
         CHK_STAT: begin
            if (stat_ready)
               state_nx = RD_DOUT;
            else if (timeout)
               state_nx = WR_STOP;
            else
               state_nx = RD_STAT;
         end
         RD_DOUT: begin
            if (beat < 3'(BEATS)) begin
               cs   = 1'b1;
               rd   = 1'b1;
               addr = ADDR_DOUT + {3'b0, beat[1:0]};
            end else begin
               state_nx = WR_STOP;
            end
         end
         WR_STOP: begin
            cs       = 1'b1;
            wr       = 1'b1;
            addr     = ADDR_CTRL;
            wdata    = ctrl_word(enc_q, 1'b0);
            state_nx = RESP;
         end
         RESP: begin
            if (bus.res_ready)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign bus.job_ready = idle_ready;
   assign bus.res_valid = (state == RESP);
   assign bus.res_data  = res_q;
   assign bus.CS        = cs;
   assign bus.Write     = wr;
   assign bus.Read      = rd;
   assign bus.Addr      = addr;
   assign bus.WData     = wdata;

endmodule
